// File: rtl/xava_result_tracker_pkg.sv
// rtl/xava_result_tracker_pkg.sv - shared constants and entry layout for the AVA result tracker
package accelerator_pkg;

  localparam int XAVA_TRK_DEPTH = 4;
  localparam int XAVA_ID_WIDTH  = 4;
  localparam int XAVA_XLEN      = 32;

  typedef struct packed {
    logic                     valid;
    logic [XAVA_ID_WIDTH-1:0] id;
    logic [4:0]               rd;
    logic                     wb;
    logic                     committed;
    logic                     killed;
    logic                     dvalid;
    logic [XAVA_XLEN-1:0]     data;
  } xava_trk_entry_t;

endpackage

// File: rtl/xava_result_tracker_if.sv
// rtl/xava_result_tracker_if.sv - request/answer bundle for the oldest-entry priority finder
interface xava_result_tracker_if
  import accelerator_pkg::*;
#(
  parameter int DEPTH = XAVA_TRK_DEPTH
) ();
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] req;
  logic [PW-1:0]    head;
  logic [PW-1:0]    idx;
  logic             found;

  modport master (output req, head, input idx, found);
  modport slave  (input req, head, output idx, found);
endinterface

// File: rtl/xava_result_tracker_oldest_match.sv
// rtl/xava_result_tracker_oldest_match.sv - rotating priority finder, oldest hit counted from head
module xava_oldest_match #(
  parameter int DEPTH = 4
) (
  xava_result_tracker_if.slave m
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] slot;

  always_comb begin
    m.idx   = '0;
    m.found = 1'b0;
    slot    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      // DEPTH is a power of two, so the slot index wraps for free
      slot = m.head + PW'(k);
      if (!m.found && m.req[slot]) begin
        m.found = 1'b1;
        m.idx   = slot;
      end
    end
  end
endmodule

// File: rtl/xava_result_tracker.sv
// rtl/xava_result_tracker.sv - in-order X-IF result tracker: allocate, commit/kill, capture, retire
module xava_result_tracker
  import accelerator_pkg::*;
#(
  parameter int DEPTH    = XAVA_TRK_DEPTH,
  parameter int ID_WIDTH = XAVA_ID_WIDTH,
  parameter int XLEN     = XAVA_XLEN
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_fire_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [4:0]          issue_rd_i,
  input  logic                issue_wb_i,
  output logic                full_o,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  input  logic                apu_rvalid_i,
  input  logic [XLEN-1:0]     apu_result_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [4:0]          result_rd_o,
  output logic [XLEN-1:0]     result_data_o,
  output logic                result_we_o,
  output logic                overflow_o,
  output logic                spurious_o
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0]    valid_q, wb_q, committed_q, killed_q, dvalid_q;
  logic [ID_WIDTH-1:0] id_q   [DEPTH];
  logic [4:0]          rd_q   [DEPTH];
  logic [XLEN-1:0]     data_q [DEPTH];
  logic [PW-1:0]       head_q, tail_q;
  logic [PW:0]         count_q;
  logic                overflow_q, spurious_q;

  logic             push, pop, head_retire;
  logic [DEPTH-1:0] cmt_req_d, dat_req_d;

  xava_result_tracker_if #(.DEPTH(DEPTH)) cmt_if ();
  xava_result_tracker_if #(.DEPTH(DEPTH)) dat_if ();

  xava_oldest_match #(.DEPTH(DEPTH)) u_cmt_match (.m(cmt_if));
  xava_oldest_match #(.DEPTH(DEPTH)) u_dat_match (.m(dat_if));

  assign full_o = (count_q == (PW+1)'(DEPTH));
  assign push   = issue_fire_i & ~full_o;

  always_comb begin
    cmt_req_d = '0;
    dat_req_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cmt_req_d[i] = commit_valid_i & valid_q[i] & ~committed_q[i] & ~killed_q[i]
                     & (id_q[i] == commit_id_i);
      dat_req_d[i] = valid_q[i] & wb_q[i] & ~dvalid_q[i];
    end
    // The slot being written this cycle is the youngest and carries no marks yet
    if (push && commit_valid_i && (issue_id_i == commit_id_i)) cmt_req_d[tail_q] = 1'b1;
  end

  assign cmt_if.req  = cmt_req_d;
  assign cmt_if.head = head_q;
  assign dat_if.req  = dat_req_d;
  assign dat_if.head = head_q;

  assign result_valid_o = valid_q[head_q] & wb_q[head_q] & committed_q[head_q]
                          & ~killed_q[head_q] & dvalid_q[head_q];
  assign result_we_o    = result_valid_o;
  assign result_id_o    = id_q[head_q];
  assign result_rd_o    = rd_q[head_q];
  assign result_data_o  = data_q[head_q];
  assign overflow_o     = overflow_q;
  assign spurious_o     = spurious_q;

  // Killed wb entries hold the head until their result arrives, keeping APU order aligned
  assign head_retire = valid_q[head_q]
                       & ((committed_q[head_q] & ~wb_q[head_q])
                          | (killed_q[head_q] & (~wb_q[head_q] | dvalid_q[head_q])));
  assign pop = (result_valid_o & result_ready_i) | head_retire;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      wb_q        <= '0;
      committed_q <= '0;
      killed_q    <= '0;
      dvalid_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]   <= '0;
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      if (push) begin
        valid_q[tail_q]     <= 1'b1;
        id_q[tail_q]        <= issue_id_i;
        rd_q[tail_q]        <= issue_rd_i;
        wb_q[tail_q]        <= issue_wb_i;
        committed_q[tail_q] <= 1'b0;
        killed_q[tail_q]    <= 1'b0;
        dvalid_q[tail_q]    <= 1'b0;
        data_q[tail_q]      <= '0;
        tail_q              <= tail_q + PW'(1);
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (cmt_if.found) begin
        if (commit_kill_i) killed_q[cmt_if.idx] <= 1'b1;
        else               committed_q[cmt_if.idx] <= 1'b1;
      end
      if (apu_rvalid_i && dat_if.found) begin
        data_q[dat_if.idx]   <= apu_result_i;
        dvalid_q[dat_if.idx] <= 1'b1;
      end
      count_q    <= count_q + (PW+1)'(push) - (PW+1)'(pop);
      overflow_q <= issue_fire_i & full_o;
      spurious_q <= apu_rvalid_i & ~dat_if.found;
    end
  end
endmodule

// File: doc/xava_result_tracker.md
# xava_result_tracker

Parametrised in-order result tracker between the AVA accelerator core and the X-IF issue/commit/result interfaces. It records every accepted offloaded instruction (id, rd, writeback flag), marks entries on commit or kill, and captures APU results in issue order. It returns results to the CPU tagged with their real instruction ID, under full `result_valid`/`result_ready` back-pressure. It replaces the single-register, id=0 result path of the first-generation adaptor.

## Interface
Parameters:
- `DEPTH`, 4: tracker entries; power of two, ≥2.
- `ID_WIDTH`, 4: X-IF instruction ID width.
- `XLEN`, 32: result data width.

Ports:
- `clk_i` in 1: clock. Single clock domain; all state on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `issue_fire_i` in 1: issue handshake completed this cycle (valid & ready & accept).
- `issue_id_i` in ID_WIDTH: ID of the issued instruction.
- `issue_rd_i` in 5: destination register, `instr[11:7]`.
- `issue_wb_i` in 1: instruction writes back a scalar result.
- `full_o` out 1: no free entry. Upstream must deassert issue ready while this is high.
- `commit_valid_i` in 1: commit transaction present.
- `commit_id_i` in ID_WIDTH: ID being committed or killed.
- `commit_kill_i` in 1: kill instead of commit.
- `apu_rvalid_i` in 1: accelerator result valid. Results arrive in issue order, one per wb instruction.
- `apu_result_i` in XLEN: accelerator result.
- `result_valid_o` out 1: X-IF result valid.
- `result_ready_i` in 1: X-IF result ready.
- `result_id_o` out ID_WIDTH, `result_rd_o` out 5, `result_data_o` out XLEN, `result_we_o` out 1: result packet fields.
- `overflow_o` out 1: one-cycle pulse when an issue is dropped while full.
- `spurious_o` out 1: one-cycle pulse when an `apu_rvalid_i` has no entry waiting for data.

## Operation
- Circular buffer with `head`/`tail` pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Entry fields: `valid`, `id`, `rd`, `wb`, `committed`, `killed`, `dvalid`, `data`.
- **Allocate:** on `issue_fire_i` with `!full_o`, write the tail entry and advance tail. On `issue_fire_i` with `full_o`, drop the issue and pulse `overflow_o`. A push is refused when full even if a pop occurs in the same cycle.
- **Commit:** mark the oldest valid, unmarked entry whose `id == commit_id_i`.
  - Kill sets `killed`; otherwise `committed` is set.
  - An entry being allocated in the same cycle is eligible for the match.
  - An unmatched ID is ignored.
- **Data capture:** on `apu_rvalid_i`, write `apu_result_i` into the oldest valid entry with `wb & !dvalid` and set `dvalid`. If no such entry exists, pulse `spurious_o` and discard the data.
- **Head output:** `result_valid_o = valid & wb & committed & !killed & dvalid` of the head entry. `result_we_o = 1` whenever valid. The id, rd and data fields come straight from the head registers.
- **Pop** (at most one per cycle) when either:
  - `result_valid_o & result_ready_i`, or
  - the head can retire silently: `committed & !wb`, or `killed & (!wb | dvalid)`.
- Killed wb entries wait for their APU result so that the result order stays aligned.
- While `result_valid_o` is high and ready is low, all result fields stay stable.

## Timing
- Reset: all entries invalid; head, tail and count = 0. Outputs `full_o`, `result_valid_o`, `overflow_o` and `spurious_o` = 0; `result_id_o`, `result_rd_o`, `result_data_o` and `result_we_o` = 0.
- Reset mid-operation discards all in-flight entries; no result is emitted afterwards for them.
- Latency: `apu_rvalid_i` in cycle N on a committed head entry gives `result_valid_o` in cycle N+1. Commit arriving after the data gives valid one cycle after the commit.
- Issue in cycle N: the entry is visible from N+1. `full_o` updates the cycle after the count reaches DEPTH.
- Issue, commit, data and pop may all occur in the same cycle. Each updates its own fields independently; count = count + push − pop.

## Structure
- Shared package `accelerator_pkg` holds:
  - the default constants `XAVA_TRK_DEPTH` and `XAVA_ID_WIDTH`;
  - the entry field layout as a packed typedef `xava_trk_entry_t`, defined at the default widths.
- One natural sub-module, `xava_oldest_match`: a rotating priority finder. Given a DEPTH-bit request vector and `head`, it returns the oldest hit index and a found flag. It is instantiated twice: once for the commit ID match and once for data capture.

## Test plan
- **In-order results:** issue IDs 1, 2 (wb) then commit both, then apu results 0xA, 0xB with ready=1 → results (id1, 0xA) then (id2, 0xB) on consecutive cycles.
- **Back-pressure:** ready=0 for 5 cycles with a result pending → valid is held, packet stable. Ready=1 → one transfer, then the next entry is presented.
- **Kill:** issue id3 (wb), id4 (wb); kill id3; results 0x11, 0x22 → 0x11 is absorbed silently and only (id4, 0x22) is emitted.
- **Full:** with DEPTH=4, issue 4 without retiring → `full_o`=1. A fifth issue → `overflow_o` pulses and the entry is not stored.
- **Same-cycle issue and commit:** issue id5 (non-wb) with commit id5 in the same cycle → the entry retires the next cycle with no result, and count returns to 0.
- **Spurious and reset:** `apu_rvalid_i` with an empty tracker → `spurious_o` pulses. `rst_i` asserted with 3 entries in flight → the next cycle shows count 0 and `result_valid_o`=0.
